// File: rtl/ula_mdu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the ula_mdu execute-stage ALU/MDU.
package ula_mdu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_NOR   = 5'd5,
    ALU_SLT   = 5'd6,
    ALU_SLTU  = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_SLLV  = 5'd11,
    ALU_SRLV  = 5'd12,
    ALU_SRAV  = 5'd13,
    ALU_JR    = 5'd14,
    ALU_MFHI  = 5'd15,
    ALU_MFLO  = 5'd16,
    ALU_MTHI  = 5'd17,
    ALU_MTLO  = 5'd18,
    ALU_MULT  = 5'd19,
    ALU_MULTU = 5'd20,
    ALU_DIV   = 5'd21,
    ALU_DIVU  = 5'd22
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/ula_mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign correction applied on the held result.
module ula_mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             fin_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d, sr_q, sr_d, m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d, div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic             a_neg, b_neg, in_div, ge;
  logic [WIDTH-1:0] a_mag, b_mag, in_acc, in_sr, in_m, addend, diff, st_acc, st_sr;
  logic [WIDTH:0]   sum, trial;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg = is_signed_i & a_i[WIDTH-1];
  assign b_neg = is_signed_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Iteration 0 runs on the accept edge from the live operands, so only WIDTH-1 cycles remain in RUN.
  always_comb begin
    if (run_q) begin
      in_acc = acc_q;
      in_sr  = sr_q;
      in_m   = m_q;
      in_div = div_q;
    end else begin
      in_acc = '0;
      in_sr  = a_mag;
      in_m   = b_mag;
      in_div = is_div_i;
    end
    addend = in_sr[0] ? in_m : '0;
    sum    = {1'b0, in_acc} + {1'b0, addend};
    trial  = {in_acc, in_sr[WIDTH-1]};
    ge     = trial >= {1'b0, in_m};
    diff   = trial[WIDTH-1:0] - in_m;
    if (in_div) begin
      st_acc = ge ? diff : trial[WIDTH-1:0];
      st_sr  = {in_sr[WIDTH-2:0], ge};
    end else begin
      st_acc = sum[WIDTH:1];
      st_sr  = {sum[0], in_sr[WIDTH-1:1]};
    end
  end

  assign fin_o  = run_q && (cnt_q == CW'(WIDTH - 1));
  assign busy_o = run_q;

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sr_d   = sr_q;
    m_d    = m_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (run_q) begin
      acc_d = st_acc;
      sr_d  = st_sr;
      cnt_d = cnt_q + 1'b1;
      if (fin_o) run_d = 1'b0;
    end else if (go_i) begin
      run_d  = 1'b1;
      cnt_d  = CW'(1);
      acc_d  = st_acc;
      sr_d   = st_sr;
      m_d    = b_mag;
      div_d  = is_div_i;
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d   = is_div_i && (b_i == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      sr_q   <= '0;
      m_q    <= '0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sr_q   <= sr_d;
      m_q    <= m_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

  // Divide by zero leaves |dividend| as remainder, so hi recovers the dividend after sign fix.
  assign prod     = {acc_q, sr_q};
  assign prod_fix = qneg_q ? -prod : prod;
  assign hi_o     = div_q ? (rneg_q ? -acc_q : acc_q) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_o     = div_q ? (dz_q ? '1 : (qneg_q ? -sr_q : sr_q)) : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/ula_mdu.sv
// Execute-stage ALU with multi-cycle MULT/DIV into HI/LO; busy stalls the pipeline.
//   state  | meaning
//   S_IDLE | accepting start; single-cycle ops complete here
//   S_RUN  | mult/div iterating, one bit per cycle
//   S_FIX  | sign-corrected result written to HI/LO/result
module ula_mdu
  import ula_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic [WIDTH-1:0] result,
  output logic             Zero_Flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_res, iter_hi, iter_lo;
  logic [SHW-1:0]   sh;
  logic             mdu_op, accept, go, issue_1c, fix_wr, iter_busy, iter_fin;

  assign sh     = In1[SHW-1:0];
  assign mdu_op = is_mdu_op(OP);

  always_comb begin
    alu_res = '0;
    case (OP)
      ALU_ADD:                   alu_res = In1 + In2;
      ALU_SUB:                   alu_res = In1 - In2;
      ALU_AND:                   alu_res = In1 & In2;
      ALU_OR:                    alu_res = In1 | In2;
      ALU_XOR:                   alu_res = In1 ^ In2;
      ALU_NOR:                   alu_res = ~(In1 | In2);
      ALU_SLT:                   alu_res = WIDTH'($signed(In1) < $signed(In2));
      ALU_SLTU:                  alu_res = WIDTH'(In1 < In2);
      ALU_SLL, ALU_SLLV:         alu_res = In2 << sh;
      ALU_SRL, ALU_SRLV:         alu_res = In2 >> sh;
      ALU_SRA, ALU_SRAV:         alu_res = $signed(In2) >>> sh;
      ALU_JR, ALU_MTHI, ALU_MTLO: alu_res = In1;
      ALU_MFHI:                  alu_res = hi_q;
      ALU_MFLO:                  alu_res = lo_q;
      default:                   alu_res = '0;
    endcase
  end

  ula_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .reset      (reset),
    .go_i       (go),
    .is_div_i   ((OP == ALU_DIV) || (OP == ALU_DIVU)),
    .is_signed_i((OP == ALU_MULT) || (OP == ALU_DIV)),
    .a_i        (In1),
    .b_i        (In2),
    .busy_o     (iter_busy),
    .fin_o      (iter_fin),
    .hi_o       (iter_hi),
    .lo_o       (iter_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && mdu_op) state_d = S_RUN;
      S_RUN: begin
        if (iter_fin)        state_d = S_FIX;
        else if (!iter_busy) state_d = S_IDLE;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept   = start && (state_q == S_IDLE);
    go       = accept && mdu_op;
    issue_1c = accept && !mdu_op;
    fix_wr   = (state_q == S_FIX);
    busy     = (state_q != S_IDLE);
    done_d   = issue_1c || fix_wr;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (issue_1c) begin
      result_d = alu_res;
      if (OP == ALU_MTHI) hi_d = In1;
      if (OP == ALU_MTLO) lo_d = In1;
    end
    if (fix_wr) begin
      hi_d     = iter_hi;
      lo_d     = iter_lo;
      result_d = iter_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign result    = result_q;
  assign Zero_Flag = (result_q == '0);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_ula_mdu.sv
// Directed bench for ula_mdu: expected results are queued at issue and checked on done.
module tb_ula_mdu;
  import ula_mdu_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [4:0]   OP;
  logic [W-1:0] In1, In2, result, hi, lo;
  logic         Zero_Flag, busy, done;

  ula_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .OP(OP), .In1(In1), .In2(In2),
    .result(result), .Zero_Flag(Zero_Flag), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output int lat);
    longint       sa, sbv, q, rm;
    logic [63:0]  p;
    logic [4:0]   s;
    s   = a[4:0];
    lat = 1;
    r   = '0;
    sa  = $signed(a);
    sbv = $signed(b);
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = (sa < sbv) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL, ALU_SLLV: r = b << s;
      ALU_SRL, ALU_SRLV: r = b >> s;
      ALU_SRA, ALU_SRAV: r = (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      ALU_JR:   r = a;
      ALU_MFHI: r = m_hi;
      ALU_MFLO: r = m_lo;
      ALU_MTHI: begin m_hi = a; r = a; end
      ALU_MTLO: begin m_lo = a; r = a; end
      ALU_MULT, ALU_MULTU: begin
        if (op == ALU_MULT) p = sa * sbv;
        else                p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
        r    = m_lo;
        lat  = W + 1;
      end
      ALU_DIV, ALU_DIVU: begin
        if (b == '0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          if (op == ALU_DIV) begin q = sa / sbv; rm = sa % sbv; end
          else begin q = longint'({32'h0, a}) / longint'({32'h0, b}); rm = longint'({32'h0, a}) % longint'({32'h0, b}); end
          m_lo = q[31:0];
          m_hi = rm[31:0];
        end
        r   = m_lo;
        lat = W + 1;
      end
      default: r = '0;
    endcase
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    start = 1'b1;
    OP    = op;
    In1   = a;
    In2   = b;
    model(op, a, b, e.res, e.lat);
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // poke > 0: at that cycle drive a conflicting start and scramble operands while busy.
  task automatic wait_done(input int poke);
    exp_t e;
    int   cyc, nbusy, extra;
    nbusy = 0;
    extra = 0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < W + 8) begin
      if (busy) nbusy++;
      start = (cyc == poke);
      if (cyc == poke) begin
        OP  = ALU_ADD;
        In1 = ~In1;
        In2 = In2 + 32'd1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_done"}, done, 1'b1);
    check({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
    check({e.tag, "_busycyc"}, 64'(nbusy), 64'(e.lat - 1));
    check({e.tag, "_busy_at_done"}, busy, 1'b0);
    check({e.tag, "_res"}, result, e.res);
    check({e.tag, "_zf"}, Zero_Flag, e.res == '0);
    check({e.tag, "_hi"}, hi, e.hi);
    check({e.tag, "_lo"}, lo, e.lo);
    if (poke > 0) begin
      repeat (4) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({e.tag, "_no_extra_done"}, 64'(extra), 64'd0);
      check({e.tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    issue(op, a, b, tag, 1'b0);
    wait_done(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; OP = '0; In1 = '0; In2 = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_zf", Zero_Flag, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;

    run(ALU_ADD,  32'd5,          32'd7,          "add_5_7");
    run(ALU_SUB,  32'd3,          32'd3,          "sub_3_3");
    run(ALU_ADD,  32'hFFFF_FFFF,  32'd2,          "add_wrap");
    run(ALU_AND,  32'hF0F0_1234,  32'h0FF0_FFFF,  "and");
    run(ALU_OR,   32'hF000_0001,  32'h0000_1000,  "or");
    run(ALU_XOR,  32'hAAAA_5555,  32'hFFFF_0000,  "xor");
    run(ALU_NOR,  32'h0000_00FF,  32'hFF00_0000,  "nor");
    run(ALU_SRA,  32'd4,          32'h8000_0000,  "sra");
    run(ALU_SLT,  32'hFFFF_FFFF,  32'd1,          "slt");
    run(ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          "sltu");
    run(ALU_SLL,  32'd31,         32'h0000_0003,  "sll31");
    run(ALU_SRLV, 32'hFFFF_FF28,  32'h8765_4321,  "srlv");
    run(ALU_SRAV, 32'h0000_0024,  32'h7000_0000,  "srav_pos");
    run(ALU_SLLV, 32'h0000_0000,  32'h1234_5678,  "sllv0");
    run(ALU_JR,   32'h0040_0010,  32'h1111_1111,  "jr");
    run(ALU_MTHI, 32'hDEAD_BEEF,  32'h0,          "mthi");
    run(ALU_MTLO, 32'h0BAD_F00D,  32'h0,          "mtlo");
    run(ALU_MFHI, 32'h0,          32'h0,          "mfhi");
    run(ALU_MFLO, 32'h0,          32'h0,          "mflo");
    run(5'd31,    32'h1234,       32'h5678,       "unknown_op");

    run(ALU_MULT,  32'hFFFF_FFFD, 32'd4,          "mult_m3_4");
    run(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  "multu_max");
    run(ALU_MULT,  32'h8000_0000, 32'h8000_0000,  "mult_min_min");
    run(ALU_MULT,  32'h0001_2345, 32'hFFF0_0001,  "mult_mixed");
    run(ALU_DIV,   32'hFFFF_FFF9, 32'd2,          "div_m7_2");
    run(ALU_DIV,   32'd7,         32'hFFFF_FFFE,  "div_7_m2");
    run(ALU_DIVU,  32'd7,         32'd0,          "divu_by0");
    run(ALU_DIV,   32'hFFFF_FF00, 32'd0,          "div_neg_by0");
    run(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  "div_min_m1");
    run(ALU_DIVU,  32'hFFFF_FFFF, 32'd10,         "divu_big");
    run(ALU_MULTU, $urandom,      $urandom,       "multu_rand");
    run(ALU_DIV,   $urandom,      $urandom_range(1, 1000), "div_rand");

    // Back-to-back issue in the done cycle, single-cycle then multi-cycle.
    issue(ALU_ADD, 32'd100, 32'd23, "b2b_a", 1'b0);
    wait_done(0);
    issue(ALU_SUB, 32'd10, 32'd4, "b2b_b", 1'b1);
    wait_done(0);
    issue(ALU_MULTU, 32'd1000, 32'd3000, "b2b_c", 1'b1);
    wait_done(0);

    issue(ALU_MULTU, 32'hCAFE_0001, 32'h0001_F00D, "multu_ignore", 1'b0);
    wait_done(5);
    run(ALU_MFHI, 32'h0, 32'h0, "mfhi_after");

    // Reset in the middle of a divide: no done, everything cleared.
    @(negedge clk);
    start = 1'b1; OP = ALU_DIV; In1 = 32'd1000; In2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("div_mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_result", result, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    ndone = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid_no_done", 64'(ndone), 64'd0);
    run(ALU_MULT, 32'd6, 32'd7, "mult_after_rst");
    run(ALU_MFLO, 32'h0, 32'h0, "mflo_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
